// File: rtl/csr_unit_if.sv
// csr_unit_if: CSR access bus between the core (master) and csr_unit (slave).
//   csr_rd      - read access this cycle
//   csr_wr_op   - 00 NOP, 01 RW, 10 RS (set), 11 RC (clear)
//   csr_addr    - 12-bit CSR address
//   csr_wdata   - write/set/clear operand
//   csr_rdata   - combinational read data (0 when not reading or unimplemented)
//   csr_illegal - combinational; unimplemented address or write to read-only space
// There is no handshake: an access is presented and completed in a single cycle.
// Reads return the pre-edge value. Writes commit at the next rising edge.
interface csr_unit_if;
  logic        csr_rd;
  logic [1:0]  csr_wr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (
    output csr_rd, csr_wr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_rd, csr_wr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR block.
//   Features: 64-bit-capable mcycle/minstret with inhibit, interrupt enable/pending,
//   prioritised interrupt request, trap entry / mret sequencing, trap vector generation.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   csr                 - CSR access bus (slave modport)
//   take_trap           - trap entry this cycle
//   trap_interrupt      - trap cause is an interrupt
//   trap_code           - trap cause code
//   trap_pc, trap_tval  - values captured into mepc / mtval
//   mret                - mret retiring this cycle
//   instret_inc         - one instruction retired this cycle
//   ext_irq, timer_irq, sw_irq - level interrupt sources
//   irq_req, irq_code   - registered interrupt request and cause code
//   trap_vector         - combinational trap target PC
//   mepc_out            - current mepc
module csr_unit #(
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HARTID      = 32'd0,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_unit_if.slave         csr,
  input  logic              take_trap,
  input  logic              trap_interrupt,
  input  logic [30:0]       trap_code,
  input  logic [31:0]       trap_pc,
  input  logic [31:0]       trap_tval,
  input  logic              mret,
  input  logic              instret_inc,
  input  logic              ext_irq,
  input  logic              timer_irq,
  input  logic              sw_irq,
  output logic              irq_req,
  output logic [30:0]       irq_code,
  output logic [31:0]       trap_vector,
  output logic [31:0]       mepc_out
);

  localparam int HW = CNT_WIDTH - 32;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCINH    = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  // Architectural state
  logic                 st_mie, st_mpie;
  logic                 en_msi, en_mti, en_mei;
  logic                 ip_msi, ip_mti, ip_mei;
  logic [29:0]          mtvec_base;
  logic                 mtvec_mode;
  logic [31:0]          mscratch, mepc, mcause, mtval;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic                 inh_cy, inh_ir;

  // Access decode
  logic        impl, access, wr_any, illegal, we;
  logic [31:0] cur_val, wval;
  logic [63:0] mcycle_ext, minstret_ext;
  logic [CNT_WIDTH-1:0] mcycle_next, minstret_next;
  logic [31:0] cy_lo_step, ir_lo_step;
  logic        ir_step;

  assign mcycle_ext   = 64'(mcycle);
  assign minstret_ext = 64'(minstret);

  // Current value of the addressed CSR, independent of csr_rd; also the
  // "old" operand for RS/RC.
  always_comb begin
    impl    = 1'b1;
    cur_val = 32'd0;
    case (csr.csr_addr)
      A_MSTATUS:   cur_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
      A_MISA:      cur_val = 32'h4000_0100;
      A_MIE:       cur_val = {20'd0, en_mei, 3'd0, en_mti, 3'd0, en_msi, 3'd0};
      A_MIP:       cur_val = {20'd0, ip_mei, 3'd0, ip_mti, 3'd0, ip_msi, 3'd0};
      A_MTVEC:     cur_val = {mtvec_base, 1'b0, mtvec_mode};
      A_MCINH:     cur_val = {29'd0, inh_ir, 1'b0, inh_cy};
      A_MSCRATCH:  cur_val = mscratch;
      A_MEPC:      cur_val = mepc;
      A_MCAUSE:    cur_val = mcause;
      A_MTVAL:     cur_val = mtval;
      A_MCYCLE:    cur_val = mcycle_ext[31:0];
      A_MCYCLEH:   cur_val = mcycle_ext[63:32];
      A_MINSTRET:  cur_val = minstret_ext[31:0];
      A_MINSTRETH: cur_val = minstret_ext[63:32];
      A_MVENDOR, A_MARCH, A_MIMP: cur_val = 32'd0;
      A_MHARTID:   cur_val = HARTID;
      default:     impl = 1'b0;
    endcase
  end

  always_comb begin
    case (csr.csr_wr_op)
      2'b01:   wval = csr.csr_wdata;
      2'b10:   wval = cur_val | csr.csr_wdata;
      2'b11:   wval = cur_val & ~csr.csr_wdata;
      default: wval = cur_val;
    endcase
  end

  assign wr_any  = (csr.csr_wr_op != 2'b00);
  assign access  = csr.csr_rd | wr_any;
  assign illegal = (access & ~impl) | (wr_any & (csr.csr_addr[11:10] == 2'b11));
  // Trap and mret outrank a CSR write in the same cycle.
  assign we      = wr_any & ~illegal & ~take_trap & ~mret;

  assign csr.csr_rdata   = (csr.csr_rd & impl) ? cur_val : 32'd0;
  assign csr.csr_illegal = illegal;

  // Counters: a low-half write replaces the low word and suppresses the
  // increment; a high-half write replaces the high part while the low word
  // still steps (its carry is discarded).
  assign cy_lo_step = mcycle[31:0] + {31'd0, ~inh_cy};
  assign ir_step    = instret_inc & ~inh_ir;
  assign ir_lo_step = minstret[31:0] + {31'd0, ir_step};

  always_comb begin
    mcycle_next = inh_cy ? mcycle : mcycle + 1'b1;
    if (we && csr.csr_addr == A_MCYCLE)
      mcycle_next = {mcycle[CNT_WIDTH-1:32], wval};
    else if (we && csr.csr_addr == A_MCYCLEH)
      mcycle_next = {wval[HW-1:0], cy_lo_step};
  end

  always_comb begin
    minstret_next = ir_step ? minstret + 1'b1 : minstret;
    if (we && csr.csr_addr == A_MINSTRET)
      minstret_next = {minstret[CNT_WIDTH-1:32], wval};
    else if (we && csr.csr_addr == A_MINSTRETH)
      minstret_next = {wval[HW-1:0], ir_lo_step};
  end

  // Vectored mode only offsets interrupts; exceptions always go to BASE.
  assign trap_vector = {mtvec_base, 2'b00} +
                       ((mtvec_mode & trap_interrupt) ? {trap_code[29:0], 2'b00} : 32'd0);
  assign mepc_out    = mepc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      en_msi     <= 1'b0;
      en_mti     <= 1'b0;
      en_mei     <= 1'b0;
      ip_msi     <= 1'b0;
      ip_mti     <= 1'b0;
      ip_mei     <= 1'b0;
      mtvec_base <= MTVEC_RESET[31:2];
      mtvec_mode <= VECTORED_EN && (MTVEC_RESET[1:0] == 2'b01);
      mscratch   <= 32'd0;
      mepc       <= 32'd0;
      mcause     <= 32'd0;
      mtval      <= 32'd0;
      mcycle     <= '0;
      minstret   <= '0;
      inh_cy     <= 1'b0;
      inh_ir     <= 1'b0;
      irq_req    <= 1'b0;
      irq_code   <= 31'd0;
    end else begin
      ip_msi   <= sw_irq;
      ip_mti   <= timer_irq;
      ip_mei   <= ext_irq;
      irq_req  <= st_mie & ((ip_mei & en_mei) | (ip_msi & en_msi) | (ip_mti & en_mti));
      if (ip_mei & en_mei)      irq_code <= 31'd11;
      else if (ip_msi & en_msi) irq_code <= 31'd3;
      else if (ip_mti & en_mti) irq_code <= 31'd7;
      else                      irq_code <= 31'd0;

      mcycle   <= mcycle_next;
      minstret <= minstret_next;

      if (take_trap) begin
        mepc    <= trap_pc & ~32'd3;
        mcause  <= {trap_interrupt, trap_code};
        mtval   <= trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (we) begin
        case (csr.csr_addr)
          A_MSTATUS: begin
            st_mie  <= wval[3];
            st_mpie <= wval[7];
          end
          A_MIE: begin
            en_msi <= wval[3];
            en_mti <= wval[7];
            en_mei <= wval[11];
          end
          A_MTVEC: begin
            mtvec_base <= wval[31:2];
            mtvec_mode <= VECTORED_EN && (wval[1:0] == 2'b01);
          end
          A_MCINH: begin
            inh_cy <= wval[0];
            inh_ir <= wval[2];
          end
          A_MSCRATCH: mscratch <= wval;
          A_MEPC:     mepc     <= wval & ~32'd3;
          A_MCAUSE:   mcause   <= wval;
          A_MTVAL:    mtval    <= wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test of csr_unit (CNT_WIDTH=40, MTVEC_RESET=0x100, HARTID=5).
module tb_csr_unit;

  logic        clk;
  logic        rst_n;
  logic        take_trap, trap_interrupt, mret, instret_inc;
  logic [30:0] trap_code;
  logic [31:0] trap_pc, trap_tval;
  logic        ext_irq, timer_irq, sw_irq;
  logic        irq_req;
  logic [30:0] irq_code;
  logic [31:0] trap_vector, mepc_out;

  int total = 0;
  int bad   = 0;

  csr_unit_if bus ();

  csr_unit #(
    .CNT_WIDTH   (40),
    .MTVEC_RESET (32'h0000_0100),
    .HARTID      (32'd5),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr            (bus),
    .take_trap      (take_trap),
    .trap_interrupt (trap_interrupt),
    .trap_code      (trap_code),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret           (mret),
    .instret_inc    (instret_inc),
    .ext_irq        (ext_irq),
    .timer_irq      (timer_irq),
    .sw_irq         (sw_irq),
    .irq_req        (irq_req),
    .irq_code       (irq_code),
    .trap_vector    (trap_vector),
    .mepc_out       (mepc_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.csr_rd   = 1'b1;
    bus.csr_addr = a;
    #1;
    d = bus.csr_rdata;
    bus.csr_rd = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
    bus.csr_wr_op = op;
    bus.csr_addr  = a;
    bus.csr_wdata = v;
    tick();
    bus.csr_wr_op = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.csr_rd = 1'b0; bus.csr_wr_op = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
    take_trap = 1'b0; trap_interrupt = 1'b0; trap_code = 31'd0; trap_pc = 32'd0; trap_tval = 32'd0;
    mret = 1'b0; instret_inc = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;

    // Reset state
    #12;
    check("rst_irq_req", {31'd0, irq_req}, 32'd0);
    check("rst_irq_code", {1'b0, irq_code}, 32'd0);
    check("rst_rdata_idle", bus.csr_rdata, 32'd0);
    check("rst_illegal", {31'd0, bus.csr_illegal}, 32'd0);
    chk_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    chk_rd("rst_mtvec", 12'h305, 32'h0000_0100);
    chk_rd("rst_mcycle", 12'hB00, 32'd0);
    chk_rd("rst_mhartid", 12'hF14, 32'd5);
    chk_rd("rst_misa", 12'h301, 32'h4000_0100);
    chk_rd("rst_mscratch", 12'h340, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RW / RS / RC on mscratch
    csr_write(2'b01, 12'h340, 32'hA5A5_A5A5);
    chk_rd("mscratch_rw", 12'h340, 32'hA5A5_A5A5);
    csr_write(2'b10, 12'h340, 32'h0000_000F);
    chk_rd("mscratch_rs", 12'h340, 32'hA5A5_A5AF);
    csr_write(2'b11, 12'h340, 32'h0000_00A0);
    chk_rd("mscratch_rc", 12'h340, 32'hA5A5_A50F);

    // Illegal accesses
    bus.csr_wr_op = 2'b01; bus.csr_addr = 12'hF11; bus.csr_wdata = 32'h1;
    #1;
    check("ro_write_illegal", {31'd0, bus.csr_illegal}, 32'd1);
    tick();
    bus.csr_wr_op = 2'b00;
    chk_rd("mvendorid_unchanged", 12'hF11, 32'd0);
    check("ro_read_legal", {31'd0, bus.csr_illegal}, 32'd0);
    bus.csr_rd = 1'b1; bus.csr_addr = 12'h7C0;
    #1;
    check("unimpl_illegal", {31'd0, bus.csr_illegal}, 32'd1);
    check("unimpl_rdata", bus.csr_rdata, 32'd0);
    bus.csr_rd = 1'b0;

    // WARL fields
    csr_write(2'b01, 12'h305, 32'h0000_2003);
    chk_rd("mtvec_mode3", 12'h305, 32'h0000_2000);
    csr_write(2'b01, 12'h305, 32'h0000_1001);
    chk_rd("mtvec_vectored", 12'h305, 32'h0000_1001);
    csr_write(2'b01, 12'h341, 32'h0000_0057);
    chk_rd("mepc_align", 12'h341, 32'h0000_0054);
    csr_write(2'b01, 12'h304, 32'hFFFF_FFFF);
    chk_rd("mie_mask", 12'h304, 32'h0000_0888);

    // Interrupt path
    csr_write(2'b01, 12'h304, 32'h0000_0800);
    csr_write(2'b10, 12'h300, 32'h0000_0008);
    chk_rd("mstatus_mie", 12'h300, 32'h0000_1808);
    ext_irq = 1'b1;
    tick();
    chk_rd("mip_meip", 12'h344, 32'h0000_0800);
    check("irq_req_not_yet", {31'd0, irq_req}, 32'd0);
    tick();
    check("irq_req_high", {31'd0, irq_req}, 32'd1);
    check("irq_code_mei", {1'b0, irq_code}, 32'd11);

    // Trap entry (vectored interrupt)
    take_trap = 1'b1; trap_interrupt = 1'b1; trap_code = 31'd11;
    trap_pc = 32'h0000_0123; trap_tval = 32'h0000_DEAD;
    #1;
    check("trap_vector_vec", trap_vector, 32'h0000_102C);
    tick();
    take_trap = 1'b0;
    check("irq_req_trap_edge", {31'd0, irq_req}, 32'd1);
    check("mepc_out", mepc_out, 32'h0000_0120);
    chk_rd("trap_mepc", 12'h341, 32'h0000_0120);
    chk_rd("trap_mcause", 12'h342, 32'h8000_000B);
    chk_rd("trap_mtval", 12'h343, 32'h0000_DEAD);
    chk_rd("trap_mstatus", 12'h300, 32'h0000_1880);
    tick();
    check("irq_req_fall", {31'd0, irq_req}, 32'd0);

    // mret
    ext_irq = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap + mret + CSR write in one cycle: only the trap lands
    take_trap = 1'b1; trap_interrupt = 1'b0; trap_code = 31'd2;
    trap_pc = 32'h0000_0201; trap_tval = 32'h0000_0077; mret = 1'b1;
    bus.csr_wr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h0000_1234;
    #1;
    check("trap_vector_exc", trap_vector, 32'h0000_1000);
    tick();
    take_trap = 1'b0; mret = 1'b0; bus.csr_wr_op = 2'b00;
    chk_rd("prio_mscratch", 12'h340, 32'hA5A5_A50F);
    chk_rd("prio_mepc", 12'h341, 32'h0000_0200);
    chk_rd("prio_mcause", 12'h342, 32'h0000_0002);
    chk_rd("prio_mstatus", 12'h300, 32'h0000_1880);

    // Interrupt priority (MIE=0 now, so no request)
    csr_write(2'b01, 12'h304, 32'h0000_0888);
    sw_irq = 1'b1; timer_irq = 1'b1;
    tick(); tick();
    check("irq_code_msi", {1'b0, irq_code}, 32'd3);
    check("irq_req_mie0", {31'd0, irq_req}, 32'd0);
    ext_irq = 1'b1;
    tick(); tick();
    check("irq_code_mei_prio", {1'b0, irq_code}, 32'd11);
    sw_irq = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
    tick(); tick();
    check("irq_code_none", {1'b0, irq_code}, 32'd0);

    // Counters
    instret_inc = 1'b1;
    tick(); tick(); tick();
    instret_inc = 1'b0;
    chk_rd("minstret_3", 12'hB02, 32'd3);
    chk_rd("minstreth_0", 12'hB82, 32'd0);
    csr_write(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick(); tick();
    chk_rd("mcycle_carry_lo", 12'hB00, 32'd1);
    chk_rd("mcycle_carry_hi", 12'hB80, 32'd1);
    csr_write(2'b01, 12'h320, 32'h0000_0005);
    chk_rd("mcountinhibit", 12'h320, 32'h0000_0005);
    instret_inc = 1'b1;
    tick(); tick();
    instret_inc = 1'b0;
    tick();
    chk_rd("mcycle_frozen", 12'hB00, 32'd2);
    chk_rd("mcycleh_frozen", 12'hB80, 32'd1);
    chk_rd("minstret_frozen", 12'hB02, 32'd3);
    csr_write(2'b01, 12'h320, 32'h0000_0000);
    csr_write(2'b01, 12'hB80, 32'hFFFF_FFFF);
    chk_rd("mcycleh_trunc", 12'hB80, 32'h0000_00FF);
    chk_rd("mcycle_hiwrite_lo", 12'hB00, 32'd3);
    csr_write(2'b01, 12'hB00, 32'hFFFF_FFFF);
    chk_rd("mcycle_pre_wrap", 12'hB00, 32'hFFFF_FFFF);
    tick();
    chk_rd("mcycle_wrap_lo", 12'hB00, 32'd0);
    chk_rd("mcycle_wrap_hi", 12'hB80, 32'd0);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk_rd("async_rst_mscratch", 12'h340, 32'd0);
    chk_rd("async_rst_mtvec", 12'h305, 32'h0000_0100);
    chk_rd("async_rst_minstret", 12'hB02, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
